// File: rtl/tpu_package.sv
// Shared TPU definitions: instruction width, opcodes, instruction field
// positions and the instruction-queue issue FSM state encoding.
package tpu_package;

  localparam int INSTR_SIZE = 49;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_MATMUL = 4'b0001;

  // Instruction field bit ranges (LSB-first packing).
  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 3;
  localparam int V_LSB    = 4;
  localparam int V_MSB    = 19;
  localparam int U_LSB    = 20;
  localparam int U_MSB    = 35;
  localparam int ITER_LSB = 36;
  localparam int ITER_MSB = 48;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } iq_state_t;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous DEPTH x INSTR_SIZE FIFO with a combinational head read.
// Storage is not reset; only the pointers and occupancy count are.
module iq_fifo
  import tpu_package::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [INSTR_SIZE-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [INSTR_SIZE-1:0] rd_data_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [INSTR_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ok, rd_ok;

  // Refuse writes when full and reads when empty so the count stays in range.
  assign wr_ok = wr_en_i && (count_q != CNT_W'(DEPTH));
  assign rd_ok = rd_en_i && (count_q != '0);

  // Pointer and count next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the write pointer; never reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/instruction_queue.sv
// Instruction queue feeding instruction_decode: buffers host pushes and
// issues one instruction per MAC completion, holding instruction_o at NOP
// outside the single issue cycle.
// Optional feature macro: TPU_IQ_OPCODE_CHECK_EN (drop non-MATMUL pushes
// and raise a sticky err_o).
module instruction_queue
  import tpu_package::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INSTR_SIZE-1:0] host_instr_i,
  input  logic                  host_valid_i,
  output logic                  host_ready_o,
  input  logic                  core_done_i,
  output logic [INSTR_SIZE-1:0] instruction_o,
  output logic                  issue_o,
  output logic [CNT_W-1:0]      queue_count_o,
  output logic                  busy_o,
  output logic                  err_o
);

  iq_state_t             state_q, state_d;
  logic [INSTR_SIZE-1:0] instr_q, instr_d;
  logic [INSTR_SIZE-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  push_acc;
  logic                  wr_en;
  logic                  pop;

  // Ready depends only on the registered count: a full queue refuses a push
  // even when a pop happens in the same cycle.
  assign host_ready_o = (count < CNT_W'(DEPTH));
  assign push_acc     = host_valid_i && host_ready_o;

`ifdef TPU_IQ_OPCODE_CHECK_EN
  logic err_q;
  logic op_ok;

  assign op_ok = (host_instr_i[OP_MSB:OP_LSB] == OP_MATMUL);
  assign wr_en = push_acc && op_ok;

  // Sticky opcode error: set by an accepted non-MATMUL push, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (push_acc && !op_ok) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign wr_en = push_acc;
  assign err_o = 1'b0;
`endif

  iq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_data_i (host_instr_i),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count)
  );

  // FSM state register plus the registered decoder bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic; the FSM looks at the registered count, so a push into
  // an empty queue is issued one cycle later at the earliest.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (count != '0) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (core_done_i) state_d = (count != '0) ? ISSUE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: every entry into ISSUE pops the head onto the decoder bus;
  // all other cycles load NOP so the decoder latches each instruction once.
  always_comb begin
    pop     = (state_d == ISSUE);
    instr_d = pop ? head : '0;
  end

  assign instruction_o = instr_q;
  assign issue_o       = (state_q == ISSUE);
  assign queue_count_o = count;
  assign busy_o        = (state_q != IDLE) || (count != '0);

endmodule
